// File: rtl/ssf_pkg.sv
// ---------------------------------------------------------------------------
// ssf_pkg
// Shared definitions for the SSF array input side: request codes, the
// sample width and the feeder state encoding.
// ---------------------------------------------------------------------------
package ssf_pkg;

  localparam int SAMPLE_W = 32;

  localparam logic [1:0] REQ_NONE = 2'b00;
  localparam logic [1:0] REQ_POP  = 2'b01;

  typedef enum logic [1:0] {
    FILL,
    RUN,
    FLUSH
  } feeder_state_t;

  // Only the exact pop code counts; 2'b10 and 2'b11 are treated as idle.
  function automatic logic is_pop(input logic [1:0] code);
    return code == REQ_POP;
  endfunction

endpackage

// File: rtl/ssf_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ssf_rr_arbiter
// Combinational round-robin arbiter. Picks the first asserted request at or
// after rr_ptr, wrapping modulo NCORES.
//
// Ports:
//   req        in  NCORES  one bit per requesting core
//   rr_ptr     in  IW      index with highest priority this cycle
//   en         in  1       arbitration allowed; no grant when low
//   grant      out NCORES  one-hot grant
//   grant_idx  out IW      index of the granted core (0 when none)
//   any_grant  out 1       a grant was issued
// ---------------------------------------------------------------------------
module ssf_rr_arbiter #(
  parameter  int NCORES = 48,
  localparam int IW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic [NCORES-1:0] req,
  input  logic [IW-1:0]     rr_ptr,
  input  logic              en,
  output logic [NCORES-1:0] grant,
  output logic [IW-1:0]     grant_idx,
  output logic              any_grant
);

  int idx;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    if (en) begin
      for (int i = 0; i < NCORES; i++) begin
        // Modulo also keeps an out-of-range rr_ptr from indexing past NCORES.
        idx = (int'(rr_ptr) + i) % NCORES;
        if (!any_grant && req[idx]) begin
          any_grant  = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = IW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/ssf_in_feeder.sv
// ---------------------------------------------------------------------------
// ssf_in_feeder
// Buffers an upstream stream of signed samples in a small FIFO and hands
// them, one per cycle, to SSF cores that raise a pop request. Round-robin
// arbitration among requesting cores; service is held off after reset or
// flush until PRIME samples are buffered.
//
// Ports:
//   clk           in  1          rising-edge clock
//   rst           in  1          synchronous active-high reset
//   s_data        in  32         upstream signed sample
//   s_valid       in  1          s_data valid
//   s_ready       out 1          sample accepted this cycle when valid
//   flush         in  1          pulse: discard buffer contents
//   req_in        in  2*NCORES   per-core request code, core k at [2k+1:2k]
//   io_in         out 32         registered sample bus to all cores
//   in_ack        out NCORES     registered one-hot owner of io_in
//   underrun_cnt  out 16         saturating count of starved RUN cycles
// ---------------------------------------------------------------------------
module ssf_in_feeder
  import ssf_pkg::*;
#(
  parameter int NCORES = 48,
  parameter int DEPTH  = 16,
  parameter int PRIME  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  input  logic [2*NCORES-1:0]   req_in,
  output logic [SAMPLE_W-1:0]   io_in,
  output logic [NCORES-1:0]     in_ack,
  output logic [15:0]           underrun_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  feeder_state_t state_q, state_d;

  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [SAMPLE_W-1:0] io_in_q;
  logic [NCORES-1:0]   in_ack_q;
  logic [15:0]         underrun_q;

  logic [NCORES-1:0]   req_vec;
  logic [NCORES-1:0]   grant;
  logic [IW-1:0]       grant_idx;
  logic                any_grant;
  logic                arb_en;
  logic                push;
  logic                pop;
  logic                starved;

  // ---------------------------------------------------------------------
  // Request decode and arbitration
  // ---------------------------------------------------------------------
  always_comb begin
    req_vec = '0;
    for (int k = 0; k < NCORES; k++) begin
      req_vec[k] = is_pop(req_in[2*k +: 2]);
    end
  end

  // count_q is registered, so a sample pushed into an empty FIFO only
  // becomes grantable one cycle later.
  assign arb_en = (state_q == RUN) && (count_q != '0);

  ssf_rr_arbiter #(
    .NCORES (NCORES)
  ) u_arb (
    .req       (req_vec),
    .rr_ptr    (rr_ptr_q),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // ---------------------------------------------------------------------
  // Handshake and event qualifiers
  // ---------------------------------------------------------------------
  // Full is judged on the registered count, so a same-cycle pop does not
  // open a slot for a push until the following cycle.
  assign s_ready = !rst && (count_q != CW'(DEPTH)) && (state_q != FLUSH);
  assign push    = s_valid && s_ready;
  assign pop     = any_grant;
  assign starved = (state_q == RUN) && (|req_vec) && (count_q == '0);

  // ---------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (flush)                       state_d = FLUSH;
        else if (count_q >= CW'(PRIME))  state_d = RUN;
      end
      RUN: begin
        if (flush) state_d = FLUSH;
      end
      FLUSH:   state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_ptr_q   <= '0;
      io_in_q    <= '0;
      in_ack_q   <= '0;
      underrun_q <= '0;
    end else begin
      state_q  <= state_d;
      in_ack_q <= grant;

      if (state_q == FLUSH) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        unique case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end

      // io_in keeps its last value on cycles without a grant.
      if (pop) begin
        io_in_q  <= mem[rd_ptr_q];
        rr_ptr_q <= (grant_idx == IW'(NCORES - 1)) ? '0 : grant_idx + IW'(1);
      end

      if (starved && (underrun_q != 16'hFFFF)) begin
        underrun_q <= underrun_q + 16'd1;
      end
    end
  end

  // NOTE: the sample storage is deliberately not reset; validity is tracked
  // entirely by the pointers and count, which are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= s_data;
    end
  end

  assign io_in        = io_in_q;
  assign in_ack       = in_ack_q;
  assign underrun_cnt = underrun_q;

endmodule
